// File: rtl/pipe_pkg.sv
// pipe_pkg: shared MIPS opcode constants, control-bundle bit positions and field-use decode.
package pipe_pkg;
    localparam int CTRL_W       = 10;
    localparam int C_REG_WRITE  = 9;
    localparam int C_MEM_READ   = 8;
    localparam int C_MEM_WRITE  = 7;
    localparam int C_MEM_TO_REG = 6;
    localparam int C_ALU_SRC    = 5;
    localparam int C_REG_DST    = 4;
    localparam int C_BRANCH     = 3;
    localparam int C_JUMP       = 2;
    localparam int C_ALU_OP_HI  = 1;
    localparam int C_ALU_OP_LO  = 0;
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    function automatic logic uses_rs(input logic [5:0] op);
        return (op != OP_J) && (op != OP_JAL);
    endfunction

    // rt is a source only where it is read; for loads and I-type ALU ops it is the destination
    function automatic logic uses_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
    endfunction
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: combinational load-use detection and IF/PC stall request.
import pipe_pkg::*;

module hazard_detect #(
    parameter int REG_AW = 5
) (
    input  logic              valid_id_i,
    input  logic [15:0]       instr_hi_i,
    input  logic              flush_id_i,
    input  logic              hold_ex_i,
    input  logic              valid_ex_i,
    input  logic              mem_read_ex_i,
    input  logic [REG_AW-1:0] rt_ex_i,
    output logic [REG_AW-1:0] rs_id_o,
    output logic [REG_AW-1:0] rt_id_o,
    output logic              load_use_o,
    output logic              stall_if_o
);
    logic [5:0] op;

    assign op      = instr_hi_i[15:10];
    assign rs_id_o = REG_AW'(instr_hi_i[9:5]);
    assign rt_id_o = REG_AW'(instr_hi_i[4:0]);

    assign load_use_o = valid_ex_i & mem_read_ex_i & (rt_ex_i != '0) & valid_id_i &
                        ((uses_rs(op) & (rs_id_o == rt_ex_i)) | (uses_rt(op) & (rt_id_o == rt_ex_i)));
    assign stall_if_o = hold_ex_i | (load_use_o & ~flush_id_i);
endmodule

// File: rtl/id_ex_pipe.sv
// id_ex_pipe: ID/EX pipeline register with immediate extension, destination select,
// load-use bubble insertion and a saturating bubble counter.
import pipe_pkg::*;

module id_ex_pipe #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_id,
    input  logic [31:0]       instr_id,
    input  logic [31:0]       pc4_id,
    input  logic [DATA_W-1:0] data1_id,
    input  logic [DATA_W-1:0] data2_id,
    input  logic [CTRL_W-1:0] ctrl_id,
    input  logic              flush_id,
    input  logic              hold_ex,
    output logic              valid_ex,
    output logic [CTRL_W-1:0] ctrl_ex,
    output logic [31:0]       pc4_ex,
    output logic [DATA_W-1:0] a_ex,
    output logic [DATA_W-1:0] b_ex,
    output logic [31:0]       imm_ex,
    output logic [4:0]        shamt_ex,
    output logic [5:0]        funct_ex,
    output logic [REG_AW-1:0] rs_ex,
    output logic [REG_AW-1:0] rt_ex,
    output logic [REG_AW-1:0] wreg_ex,
    output logic              stall_if,
    output logic [CNT_W-1:0]  bubble_cnt
);
    logic              valid_q, valid_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [31:0]       pc4_q, pc4_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic [31:0]       imm_q, imm_d;
    logic [4:0]        shamt_q, shamt_d;
    logic [5:0]        funct_q, funct_d;
    logic [REG_AW-1:0] rs_q, rs_d, rt_q, rt_d, wreg_q, wreg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [REG_AW-1:0] rs_id, rt_id, rd_id;
    logic              load_use, bubble, load;

    hazard_detect #(.REG_AW(REG_AW)) u_hazard (
        .valid_id_i    (valid_id),
        .instr_hi_i    (instr_id[31:16]),
        .flush_id_i    (flush_id),
        .hold_ex_i     (hold_ex),
        .valid_ex_i    (valid_q),
        .mem_read_ex_i (ctrl_q[C_MEM_READ]),
        .rt_ex_i       (rt_q),
        .rs_id_o       (rs_id),
        .rt_id_o       (rt_id),
        .load_use_o    (load_use),
        .stall_if_o    (stall_if)
    );

    assign rd_id  = REG_AW'(instr_id[15:11]);
    assign bubble = flush_id | load_use;
    assign load   = valid_id & ~bubble;

    // hold_ex freezes everything, including a pending flush which upstream keeps asserted
    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        pc4_d   = pc4_q;
        a_d     = a_q;
        b_d     = b_q;
        imm_d   = imm_q;
        shamt_d = shamt_q;
        funct_d = funct_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        wreg_d  = wreg_q;
        cnt_d   = cnt_q;
        if (!hold_ex) begin
            valid_d = load;
            ctrl_d  = load ? ctrl_id : '0;
            pc4_d   = bubble ? '0 : pc4_id;
            a_d     = bubble ? '0 : data1_id;
            b_d     = bubble ? '0 : data2_id;
            imm_d   = bubble ? '0 : {{16{instr_id[15]}}, instr_id[15:0]};
            shamt_d = bubble ? '0 : instr_id[10:6];
            funct_d = bubble ? '0 : instr_id[5:0];
            rs_d    = bubble ? '0 : rs_id;
            rt_d    = bubble ? '0 : rt_id;
            wreg_d  = bubble ? '0 : (ctrl_id[C_REG_DST] ? rd_id : rt_id);
            cnt_d   = (load_use && !flush_id && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            pc4_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            imm_q   <= '0;
            shamt_q <= '0;
            funct_q <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            wreg_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            pc4_q   <= pc4_d;
            a_q     <= a_d;
            b_q     <= b_d;
            imm_q   <= imm_d;
            shamt_q <= shamt_d;
            funct_q <= funct_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            wreg_q  <= wreg_d;
            cnt_q   <= cnt_d;
        end
    end

    assign valid_ex   = valid_q;
    assign ctrl_ex    = ctrl_q;
    assign pc4_ex     = pc4_q;
    assign a_ex       = a_q;
    assign b_ex       = b_q;
    assign imm_ex     = imm_q;
    assign shamt_ex   = shamt_q;
    assign funct_ex   = funct_q;
    assign rs_ex      = rs_q;
    assign rt_ex      = rt_q;
    assign wreg_ex    = wreg_q;
    assign bubble_cnt = cnt_q;
endmodule

// File: tb/tb_id_ex_pipe.sv
// tb_id_ex_pipe: table-driven directed vectors plus hand sequences for hold, reset-in-hold
// and counter saturation (4-bit counter build).
module tb_id_ex_pipe;
    logic        clk = 1'b0;
    logic        rst, valid_id, flush_id, hold_ex;
    logic [31:0] instr_id, pc4_id, data1_id, data2_id;
    logic [9:0]  ctrl_id;
    logic        valid_ex, stall_if;
    logic [9:0]  ctrl_ex;
    logic [31:0] pc4_ex, a_ex, b_ex, imm_ex;
    logic [4:0]  shamt_ex, rs_ex, rt_ex, wreg_ex;
    logic [5:0]  funct_ex;
    logic [3:0]  bubble_cnt;
    int          total = 0;
    int          bad = 0;

    id_ex_pipe #(.DATA_W(32), .REG_AW(5), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .valid_id(valid_id), .instr_id(instr_id), .pc4_id(pc4_id),
        .data1_id(data1_id), .data2_id(data2_id), .ctrl_id(ctrl_id), .flush_id(flush_id),
        .hold_ex(hold_ex), .valid_ex(valid_ex), .ctrl_ex(ctrl_ex), .pc4_ex(pc4_ex),
        .a_ex(a_ex), .b_ex(b_ex), .imm_ex(imm_ex), .shamt_ex(shamt_ex), .funct_ex(funct_ex),
        .rs_ex(rs_ex), .rt_ex(rt_ex), .wreg_ex(wreg_ex), .stall_if(stall_if),
        .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rst, hold, flush, v, instr, ctrl, d1, d2, pc;
        logic [31:0] st, vex, cex, aex, bex, wreg, imm, pcx, cnt;
    } vec_t;

    vec_t tv[17];

    function automatic vec_t mk(input logic [31:0] r, h, f, v, ins, c, d1, d2, pc,
                                input logic [31:0] st, vex, cex, aex, bex, wreg, imm, pcx, cnt);
        vec_t t;
        t.rst = r; t.hold = h; t.flush = f; t.v = v; t.instr = ins; t.ctrl = c;
        t.d1 = d1; t.d2 = d2; t.pc = pc; t.st = st; t.vex = vex; t.cex = cex;
        t.aex = aex; t.bex = bex; t.wreg = wreg; t.imm = imm; t.pcx = pcx; t.cnt = cnt;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, h, f, v, input logic [31:0] ins, input logic [9:0] c,
                         input logic [31:0] d1, d2, pc);
        rst = r; hold_ex = h; flush_id = f; valid_id = v; instr_id = ins; ctrl_id = c;
        data1_id = d1; data2_id = d2; pc4_id = pc;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // ctrl bundles: lw=0x360, R-type=0x212, addi=0x220, j=0x004, sw=0x0A0
    initial begin
        tv[0]  = mk(1,1,0,1,'h00222020,'h212,4,7,'h40,       1, 0,0,0,0,0,0,0,0);
        tv[1]  = mk(1,0,1,1,'h8C23FFFC,'h360,1,2,'h44,       0, 0,0,0,0,0,0,0,0);
        tv[2]  = mk(0,0,0,1,'h00222020,'h212,4,7,'h104,      0, 1,'h212,4,7,4,'h2020,'h104,0);
        tv[3]  = mk(0,0,0,1,'h8C23FFFC,'h360,'h1000,9,'h108, 0, 1,'h360,'h1000,9,3,'hFFFFFFFC,'h108,0);
        tv[4]  = mk(0,0,0,1,'h00622020,'h212,5,6,'h10C,      1, 0,0,0,0,0,0,0,1);
        tv[5]  = mk(0,0,0,1,'h00622020,'h212,'h55,6,'h10C,   0, 1,'h212,'h55,6,4,'h2020,'h10C,1);
        tv[6]  = mk(0,0,0,1,'h8C230000,'h360,1,2,'h110,      0, 1,'h360,1,2,3,0,'h110,1);
        // j whose target bits alias rs=$3: must not be treated as reading rs
        tv[7]  = mk(0,0,0,1,'h08600100,'h004,0,0,'h114,      0, 1,'h004,0,0,0,'h100,'h114,1);
        tv[8]  = mk(0,0,0,1,'h8C200000,'h360,8,0,'h118,      0, 1,'h360,8,0,0,0,'h118,1);
        tv[9]  = mk(0,0,0,1,'h00022020,'h212,0,3,'h11C,      0, 1,'h212,0,3,4,'h2020,'h11C,1);
        tv[10] = mk(0,0,0,1,'h8C230000,'h360,2,0,'h120,      0, 1,'h360,2,0,3,0,'h120,1);
        tv[11] = mk(0,0,0,1,'h20A30001,'h220,'h10,'h11,'h124,0, 1,'h220,'h10,'h11,3,1,'h124,1);
        tv[12] = mk(0,0,0,1,'h8C230000,'h360,3,4,'h128,      0, 1,'h360,3,4,3,0,'h128,1);
        tv[13] = mk(0,0,1,1,'h00622020,'h212,7,8,'h12C,      0, 0,0,0,0,0,0,0,1);
        tv[14] = mk(0,0,0,1,'h8C230000,'h360,1,1,'h130,      0, 1,'h360,1,1,3,0,'h130,1);
        tv[15] = mk(0,0,0,1,'hAC230000,'h0A0,1,2,'h134,      1, 0,0,0,0,0,0,0,2);
        tv[16] = mk(0,0,0,1,'hAC230000,'h0A0,1,2,'h134,      0, 1,'h0A0,1,2,3,0,'h134,2);

        drive(1,0,0,0,0,0,0,0,0);
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 17; i++) begin
            drive(tv[i].rst[0], tv[i].hold[0], tv[i].flush[0], tv[i].v[0], tv[i].instr,
                  tv[i].ctrl[9:0], tv[i].d1, tv[i].d2, tv[i].pc);
            #1;
            chk($sformatf("stall[%0d]", i), 32'(stall_if), tv[i].st);
            tick();
            chk($sformatf("valid[%0d]", i), 32'(valid_ex), tv[i].vex);
            chk($sformatf("ctrl[%0d]", i), 32'(ctrl_ex), tv[i].cex);
            chk($sformatf("a[%0d]", i), a_ex, tv[i].aex);
            chk($sformatf("b[%0d]", i), b_ex, tv[i].bex);
            chk($sformatf("wreg[%0d]", i), 32'(wreg_ex), tv[i].wreg);
            chk($sformatf("imm[%0d]", i), imm_ex, tv[i].imm);
            chk($sformatf("pc4[%0d]", i), pc4_ex, tv[i].pcx);
            chk($sformatf("cnt[%0d]", i), 32'(bubble_cnt), tv[i].cnt);
        end

        // hold with a pending flush: EX keeps the sw, flush lands after release
        for (int i = 0; i < 3; i++) begin
            drive(0,1,1,1,'h00222020,'h212,9,9,'h200);
            #1;
            chk("hold_stall", 32'(stall_if), 1);
            tick();
            chk("hold_valid", 32'(valid_ex), 1);
            chk("hold_ctrl", 32'(ctrl_ex), 'h0A0);
            chk("hold_a", a_ex, 1);
            chk("hold_wreg", 32'(wreg_ex), 3);
        end
        drive(0,0,1,1,'h00222020,'h212,9,9,'h200);
        #1;
        chk("rel_stall", 32'(stall_if), 0);
        tick();
        chk("rel_valid", 32'(valid_ex), 0);
        chk("rel_ctrl", 32'(ctrl_ex), 0);
        chk("rel_cnt", 32'(bubble_cnt), 2);
        drive(0,0,0,1,'h00222020,'h212,9,9,'h200);
        tick();
        chk("post_valid", 32'(valid_ex), 1);
        chk("post_a", a_ex, 9);
        chk("post_funct", 32'(funct_ex), 'h20);
        chk("post_rs", 32'(rs_ex), 1);
        chk("post_rt", 32'(rt_ex), 2);

        // reset overrides hold
        drive(1,1,0,1,'h00222020,'h212,9,9,'h200);
        tick();
        chk("rsthold_valid", 32'(valid_ex), 0);
        chk("rsthold_a", a_ex, 0);
        chk("rsthold_cnt", 32'(bubble_cnt), 0);

        // 20 load-use hazards against a 4-bit counter
        for (int i = 0; i < 20; i++) begin
            drive(0,0,0,1,'h8C230000,'h360,1,1,'h300);
            tick();
            drive(0,0,0,1,'h00622020,'h212,2,2,'h304);
            #1;
            chk($sformatf("sat_stall[%0d]", i), 32'(stall_if), 1);
            tick();
            chk($sformatf("sat_cnt[%0d]", i), 32'(bubble_cnt), (i + 1 > 15) ? 15 : i + 1);
        end
        chk("sat_final", 32'(bubble_cnt), 15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
